// File: rtl/uart_rx_pkg.sv
// Shared types, limits and config helpers for the UART receive controller.
package uart_rx_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, LOAD} rx_state_t;

   localparam int                    BIT_PERIOD_W   = 14;
   localparam logic [BIT_PERIOD_W-1:0] MIN_BIT_PERIOD = 14'd4;
   localparam logic [3:0]            MIN_DATA_SIZE  = 4'd5;
   localparam logic [3:0]            MAX_DATA_SIZE  = 4'd8;

   function automatic logic [BIT_PERIOD_W-1:0] clamp_period(input logic [BIT_PERIOD_W-1:0] p);
      return (p < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : p;
   endfunction

   function automatic logic [3:0] clamp_size(input logic [3:0] n);
      if (n < MIN_DATA_SIZE) return MIN_DATA_SIZE;
      if (n > MAX_DATA_SIZE) return MAX_DATA_SIZE;
      return n;
   endfunction

   // n is always a clamped size (5..8)
   function automatic logic [7:0] size_mask(input logic [3:0] n);
      return 8'hFF >> (MAX_DATA_SIZE - n);
   endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Register-block side bundle of the UART receive controller.
// Parity signals exist only when PARITY_CHECK_EN is defined.
interface uart_rx_controller_if;
   import uart_rx_pkg::*;

   logic [BIT_PERIOD_W-1:0] bit_period;
   logic [3:0]              data_size;
   logic                    data_read;
   logic [7:0]              rx_data;
   logic                    data_ready;
   logic                    overrun_error;
   logic                    framing_error;
   logic                    busy;
`ifdef PARITY_CHECK_EN
   logic                    parity_en;
   logic                    parity_odd;
   logic                    parity_error;

   modport master (output bit_period, data_size, data_read, parity_en, parity_odd,
                   input  rx_data, data_ready, overrun_error, framing_error, busy, parity_error);
   modport slave  (input  bit_period, data_size, data_read, parity_en, parity_odd,
                   output rx_data, data_ready, overrun_error, framing_error, busy, parity_error);
`else
   modport master (output bit_period, data_size, data_read,
                   input  rx_data, data_ready, overrun_error, framing_error, busy);
   modport slave  (input  bit_period, data_size, data_read,
                   output rx_data, data_ready, overrun_error, framing_error, busy);
`endif

endinterface

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter; o_expire fires i_load_value cycles after a load.
module uart_rx_bit_timer
   import uart_rx_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_load,
   input  logic [BIT_PERIOD_W-1:0] i_load_value,
   input  logic                    i_enable,
   output logic                    o_expire
);

   logic [BIT_PERIOD_W-1:0] r_count;

   // Stores value-1 so a reload on the expire cycle gives an exact period.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_value - 1'b1;
      else if (i_enable && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign o_expire = i_enable && (r_count == '0);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive controller: line sync, frame sequencing, byte/flag delivery.
// Optional parity check enabled by defining PARITY_CHECK_EN.
//   state  | meaning
//   IDLE   | waiting for a falling start edge
//   START  | half-bit wait, confirm start bit is still low
//   DATA   | sampling data bits mid-bit, LSB first
//   PARITY | sampling the parity bit (parity builds only)
//   STOP   | sampling the stop bit
//   LOAD   | one cycle: publish byte and flags
module uart_rx_controller
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_serial_in,
   uart_rx_controller_if.slave rx_if
);

   rx_state_t               r_state, w_state_next;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    r_prev;
   logic [BIT_PERIOD_W-1:0] r_period, w_tmr_value;
   logic [3:0]              r_size, r_bit_cnt;
   logic [7:0]              r_shift, w_shift_next, r_rx_data, w_mask;
   logic [2:0]              w_msb_idx;
   logic                    r_ready, r_overrun, r_frame_err;
   logic                    w_sample, w_start_edge, w_last_bit, w_read;
   logic                    w_tmr_load, w_tmr_en, w_expire;
`ifdef PARITY_CHECK_EN
   logic                    r_par_en, r_par_odd, r_par_bit, r_par_err;
`endif

   assign w_sample     = r_sync[SYNC_STAGES-1];
   assign w_start_edge = r_prev & ~w_sample;
   assign w_msb_idx    = 3'(r_size - 4'd1);
   assign w_last_bit   = (r_bit_cnt + 4'd1) == r_size;
   assign w_mask       = size_mask(r_size);
   assign w_read       = rx_if.data_read & r_ready;

   // Reset to idle-high so reset itself never looks like a start edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_serial_in};
         r_prev <= w_sample;
      end
   end

   uart_rx_bit_timer u_bit_timer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_load       (w_tmr_load),
      .i_load_value (w_tmr_value),
      .i_enable     (w_tmr_en),
      .o_expire     (w_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_tmr_load   = 1'b0;
      w_tmr_value  = r_period;
      w_tmr_en     = (r_state != IDLE) && (r_state != LOAD);
      case (r_state)
         IDLE: if (w_start_edge) begin
            w_state_next = START;
            w_tmr_load   = 1'b1;
            w_tmr_value  = clamp_period(rx_if.bit_period) >> 1;
         end
         START: if (w_expire) begin
            w_tmr_load   = 1'b1;
            w_state_next = w_sample ? IDLE : DATA;
         end
         DATA: if (w_expire) begin
            w_tmr_load = 1'b1;
`ifdef PARITY_CHECK_EN
            if (w_last_bit) w_state_next = r_par_en ? PARITY : STOP;
`else
            if (w_last_bit) w_state_next = STOP;
`endif
         end
`ifdef PARITY_CHECK_EN
         PARITY: if (w_expire) begin
            w_tmr_load   = 1'b1;
            w_state_next = STOP;
         end
`endif
         STOP: if (w_expire) w_state_next = LOAD;
         LOAD: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_shift_next            = {1'b0, r_shift[7:1]};
      w_shift_next[w_msb_idx] = w_sample;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_period    <= MIN_BIT_PERIOD;
         r_size      <= MAX_DATA_SIZE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_ready     <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
         r_par_en    <= 1'b0;
         r_par_odd   <= 1'b0;
         r_par_bit   <= 1'b0;
         r_par_err   <= 1'b0;
`endif
      end else begin
         if (r_state == IDLE && w_start_edge) begin
            r_period  <= clamp_period(rx_if.bit_period);
            r_size    <= clamp_size(rx_if.data_size);
`ifdef PARITY_CHECK_EN
            r_par_en  <= rx_if.parity_en;
            r_par_odd <= rx_if.parity_odd;
`endif
         end
         if (r_state == START && w_expire) r_bit_cnt <= '0;
         if (r_state == DATA && w_expire) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
`ifdef PARITY_CHECK_EN
         if (r_state == PARITY && w_expire) r_par_bit <= w_sample;
`endif
         if (r_state == STOP && w_expire) r_frame_err <= ~w_sample;
         if (r_state == LOAD) begin
            r_rx_data <= r_shift & w_mask;
            r_ready   <= 1'b1;
            if (r_ready && !rx_if.data_read) r_overrun <= 1'b1;
            else if (w_read)                 r_overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_err <= r_par_en & ((^(r_shift & w_mask) ^ r_par_bit) != r_par_odd);
`endif
         end else if (w_read) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   assign rx_if.rx_data       = r_rx_data;
   assign rx_if.data_ready    = r_ready;
   assign rx_if.overrun_error = r_overrun;
   assign rx_if.framing_error = r_frame_err;
   assign rx_if.busy          = (r_state != IDLE);
`ifdef PARITY_CHECK_EN
   assign rx_if.parity_error  = r_par_err;
`endif

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Receive control unit for the APB UART receiver. It oversamples the serial line and sequences start, data and stop bit sampling. It uses the bit_period and data_size values from the APB register block. It produces rx_data, data_ready, overrun_error and framing_error for that block, and clears them on data_read.

Parameters:
SYNC_STAGES, 2, number of flops in the serial_in synchronizer (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  asynchronous UART line, idle high
bit_period  input  14  clocks per bit
data_size  input  4  data bits per frame
data_read  input  1  1-cycle pulse: host consumed rx_data
rx_data  output  8  received byte, right-justified, upper bits zero
data_ready  output  1  unread byte available
overrun_error  output  1  byte overwritten before read
framing_error  output  1  last frame had stop bit = 0
busy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (rst high at a clk edge):
  - Outputs: rx_data=0, data_ready=0, overrun_error=0, framing_error=0, busy=0.
  - FSM goes to IDLE.
  - Synchronizer flops load 1.
  - Reset mid-frame aborts the frame with no output update.
- Line input:
  - serial_in passes through SYNC_STAGES flops, then one edge-detect flop.
  - start_edge = previous synced 1 and current synced 0.
- Config latch on start_edge:
  - bit_period is latched. Values <4 are clamped to 4.
  - data_size is latched. Values <5 are clamped to 5; values >8 are clamped to 8.
  - Mid-frame config changes are ignored.
- FSM states: IDLE, START, DATA, STOP, LOAD.
  - IDLE: start_edge -> START, timer loaded with latched_period>>1.
  - START: the timer counts down one per cycle. Sample at zero.
    - Sample 0 -> DATA, timer=latched_period, bit_cnt=0.
    - Sample 1 -> IDLE (false start, no flags change).
  - DATA: sample each time the timer expires, then reload the timer.
    - Shift right, LSB first: the sample enters bit data_size-1 of an 8-bit shift register.
    - bit_cnt increments. When bit_cnt reaches latched data_size -> STOP.
  - STOP: sample after one latched_period.
    - framing_error <= ~sample. It is set or cleared by every completed frame.
    - -> LOAD.
  - LOAD (1 cycle):
    - rx_data <= shift reg, with bits above data_size forced 0.
    - data_ready <= 1.
    - overrun_error <= 1 if data_ready was already 1 and data_read is not asserted this cycle.
    - -> IDLE.
  - A framing-error frame is still loaded.
- Latency: data_ready rises exactly 1 cycle after the stop sample edge.
  - The stop sample falls at (latched_period>>1) + (data_size+1)*latched_period clocks after start_edge.
- data_read:
  - Clears data_ready and overrun_error on the next edge.
  - Ignored when data_ready=0.
  - Does not clear framing_error.
- Simultaneous LOAD and data_read: data_ready stays 1, overrun_error is not set, rx_data takes the new byte.
- Overrun policy: the newest byte always overwrites rx_data.
- Back-to-back frames: a start edge is recognised the cycle after LOAD. A line held low after a framing error generates no new start until it returns high.
- Timer is 14-bit and never wraps. Reload happens in the same cycle as the expire sample.

Optional Feature:
PARITY_CHECK_EN

With the macro defined:
- Extra ports:
  - parity_en input 1
  - parity_odd input 1
  - parity_error output 1, reset 0
- Both parity inputs are latched at start_edge.
- If latched parity_en=1, a PARITY state between DATA and STOP samples one extra bit after one latched_period.
- parity_error <= (XOR of data bits XOR parity bit) != latched parity_odd. It is updated in LOAD.
- data_ready latency grows by latched_period.

Without the macro:
- No parity ports and no PARITY state.
- Frame is start + data + stop only.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, LOAD)
  - MIN_BIT_PERIOD=4, MIN_DATA_SIZE=5, MAX_DATA_SIZE=8
  - BIT_PERIOD_W=14
- Sub-module uart_rx_bit_timer:
  - Loadable 14-bit down-counter.
  - Inputs: load, load_value, enable.
  - Output: expire pulse, 1 cycle at count zero.
  - Instantiated once.
- FSM, shift register and flags stay in the top.

Test Plan:
- Reset values: rst pulsed mid-frame (bit_period=10, frame 0xA5 in progress) -> all outputs 0, FSM IDLE; the next full frame 0x3C gives rx_data=0x3C.
- Nominal 8N1: bit_period=10, data_size=8, send 0xA5 -> data_ready rises 95+1 cycles after start_edge, rx_data=0xA5, framing_error=0; data_read pulse -> data_ready=0 next cycle.
- Size/clamp: data_size=5, send 0x1F then 0x15 -> rx_data=0x1F then 0x15. data_size=12 -> treated as 8. bit_period=1 -> timing as bit_period=4.
- False start and framing: a 3-cycle low glitch with bit_period=16 -> no data_ready. A frame with stop=0 -> framing_error=1 and byte loaded; the next good frame clears it.
- Overrun: two frames 0x11 then 0x22 with no data_read -> overrun_error=1, rx_data=0x22; data_read coincident with the second LOAD -> overrun_error stays 0.
- PARITY_CHECK_EN build: parity_en=1, parity_odd=0, byte 0x07 with parity bit 1 -> parity_error=0; with parity bit 0 -> parity_error=1.
